// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler: hazard
// classes, ID-stage forward codes and the EX scoreboard entry layout.
package hazard_pkg;

    // Width of register addresses held in the scoreboard (RV32I: x0..x31).
    localparam int SB_AW = 5;

    // Hazard class reported by the decoder for the instruction in ID.
    localparam logic [1:0] OPT_NONE  = 2'd0;
    localparam logic [1:0] OPT_ALU   = 2'd1;
    localparam logic [1:0] OPT_LOAD  = 2'd2;
    localparam logic [1:0] OPT_STORE = 2'd3;

    // Operand source selects for the ID-stage operand muxes.
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    // One scoreboard entry: what an in-flight instruction will write and,
    // for stores, which register supplies the store data.
    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic [1:0]       optype;
        logic [SB_AW-1:0] rs2;
        logic             is_store;
    } sb_entry_t;

    // Operand source priority: the youngest producer (EX) wins. An EX load
    // cannot be forwarded from ID, so it falls through to the MEM checks;
    // that case is covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(
        input logic       ex_hit,
        input logic [1:0] ex_opt,
        input logic       mem_hit,
        input logic [1:0] mem_opt
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit && (ex_opt == OPT_ALU)) begin
            sel = FWD_EX_ALU;
        end else if (mem_hit && (mem_opt == OPT_ALU)) begin
            sel = FWD_MEM_ALU;
        end else if (mem_hit && (mem_opt == OPT_LOAD)) begin
            sel = FWD_MEM_LD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard entry against one source register and reports
// whether the entry produces that register, plus the entry's hazard class.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int AW = SB_AW
)
(
    input  logic          ent_vld,
    input  logic [AW-1:0] ent_rd,
    input  logic [1:0]    ent_opt,
    input  logic [AW-1:0] rs,
    input  logic          rs_use,
    output logic          hit,
    output logic [1:0]    opt
);

    logic writes_rd;

    // An entry produces a value only for ALU/LOAD classes and never for x0.
    always_comb begin
        writes_rd = ent_vld
                 && ((ent_opt == OPT_ALU) || (ent_opt == OPT_LOAD))
                 && (ent_rd != '0);
        hit       = rs_use && (rs != '0) && writes_rd && (ent_rd == rs);
        opt       = ent_opt;
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard scheduler for the 5-stage RV32I core: tracks EX and MEM producers,
// generates operand forwards, the load-use stall and the PC/IF-ID/ID-EX
// enables and flushes. All outputs are combinational.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs1use,
    input  logic              id_rs2use,
    input  logic [1:0]        id_optype,
    input  logic              id_branch,
    input  logic              trap_redirect,
    input  logic              stall_ext,
    output logic              pc_en,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_ls
);

    // Scoreboard addresses are SB_AW wide; REG_AW must not exceed it.
    localparam int AW = SB_AW;

    logic [AW-1:0] rs1_id;
    logic [AW-1:0] rs2_id;
    logic [AW-1:0] rd_id;

    // EX entry (full record) and MEM entry (only what forwarding needs).
    sb_entry_t     ex_p1;
    sb_entry_t     ex_nxt;
    logic          vld_p2;
    logic [AW-1:0] rd_p2;
    logic [1:0]    opt_p2;

    logic          ex1_hit;
    logic [1:0]    ex1_opt;
    logic          ex2_hit;
    logic [1:0]    ex2_opt;
    logic          mem1_hit;
    logic [1:0]    mem1_opt;
    logic          mem2_hit;
    logic [1:0]    mem2_opt;
    logic          ls_hit;
    logic [1:0]    ls_opt;
    logic          ls_use;
    logic          lu;

    assign rs1_id = AW'(id_rs1);
    assign rs2_id = AW'(id_rs2);
    assign rd_id  = AW'(id_rd);

    // ID operands against the EX producer.
    hazard_match #(.AW(AW)) u_ex_rs1 (
        .ent_vld (ex_p1.valid),
        .ent_rd  (ex_p1.rd),
        .ent_opt (ex_p1.optype),
        .rs      (rs1_id),
        .rs_use  (id_rs1use),
        .hit     (ex1_hit),
        .opt     (ex1_opt)
    );

    hazard_match #(.AW(AW)) u_ex_rs2 (
        .ent_vld (ex_p1.valid),
        .ent_rd  (ex_p1.rd),
        .ent_opt (ex_p1.optype),
        .rs      (rs2_id),
        .rs_use  (id_rs2use),
        .hit     (ex2_hit),
        .opt     (ex2_opt)
    );

    // ID operands against the MEM producer.
    hazard_match #(.AW(AW)) u_mem_rs1 (
        .ent_vld (vld_p2),
        .ent_rd  (rd_p2),
        .ent_opt (opt_p2),
        .rs      (rs1_id),
        .rs_use  (id_rs1use),
        .hit     (mem1_hit),
        .opt     (mem1_opt)
    );

    hazard_match #(.AW(AW)) u_mem_rs2 (
        .ent_vld (vld_p2),
        .ent_rd  (rd_p2),
        .ent_opt (opt_p2),
        .rs      (rs2_id),
        .rs_use  (id_rs2use),
        .hit     (mem2_hit),
        .opt     (mem2_opt)
    );

    // Store data of the store in EX against a load sitting in MEM.
    assign ls_use = ex_p1.valid && ex_p1.is_store;

    hazard_match #(.AW(AW)) u_ls (
        .ent_vld (vld_p2),
        .ent_rd  (rd_p2),
        .ent_opt (opt_p2),
        .rs      (ex_p1.rs2),
        .rs_use  (ls_use),
        .hit     (ls_hit),
        .opt     (ls_opt)
    );

    // Forward selects, load-use detection and the prioritised pipeline controls.
    always_comb begin
        fwd_a  = fwd_sel(ex1_hit, ex1_opt, mem1_hit, mem1_opt);
        fwd_b  = fwd_sel(ex2_hit, ex2_opt, mem2_hit, mem2_opt);
        fwd_ls = ls_hit && (ls_opt == OPT_LOAD);

        // A store whose only dependency on the EX load is its data operand
        // can proceed; the data is picked up later through fwd_ls.
        lu = (ex1_hit && (ex1_opt == OPT_LOAD))
          || (ex2_hit && (ex2_opt == OPT_LOAD) && (id_optype != OPT_STORE));

        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (stall_ext) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
        end else if (trap_redirect) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (lu) begin
            // Branch operands are not ready yet, so id_branch waits a cycle.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (id_branch) begin
            fd_flush = 1'b1;
        end
    end

    // Record the ID instruction as the next EX entry; a flushed slot is a bubble.
    always_comb begin
        ex_nxt          = '0;
        ex_nxt.valid    = !de_flush;
        ex_nxt.rd       = rd_id;
        ex_nxt.optype   = id_optype;
        ex_nxt.rs2      = rs2_id;
        ex_nxt.is_store = (id_optype == OPT_STORE);
    end

    // ---- ID -> EX (p1) and EX -> MEM (p2) scoreboard advance ----
    // Valid bits and EX entry: cleared by reset and by a trap redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p1  <= '0;
            vld_p2 <= 1'b0;
        end else if (!stall_ext) begin
            if (trap_redirect) begin
                ex_p1.valid <= 1'b0;
                vld_p2      <= 1'b0;
            end else begin
                ex_p1  <= ex_nxt;
                vld_p2 <= ex_p1.valid;
            end
        end
    end

    // MEM payload follows EX; meaningful only while vld_p2 is set.
    always_ff @(posedge clk) begin
        if (!stall_ext) begin
            rd_p2  <= ex_p1.rd;
            opt_p2 <= ex_p1.optype;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random stimulus for hazard_unit against a cycle-level
// reference model of the in-flight EX/MEM instructions.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_rs1use;
    logic       id_rs2use;
    logic [1:0] id_optype;
    logic       id_branch;
    logic       trap_redirect;
    logic       stall_ext;
    logic       pc_en;
    logic       fd_en;
    logic       fd_flush;
    logic       de_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       fwd_ls;

    int total = 0;
    int bad   = 0;

    // Reference model: slot 0 = instruction in EX, slot 1 = instruction in MEM.
    bit         mv   [2];
    logic [4:0] mrd  [2];
    logic [1:0] mop  [2];
    logic [4:0] mrs2 [2];

    logic       e_pc, e_fd, e_ff, e_df, e_ls;
    logic [1:0] e_a, e_b;

    hazard_unit #(.REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1use     (id_rs1use),
        .id_rs2use     (id_rs2use),
        .id_optype     (id_optype),
        .id_branch     (id_branch),
        .trap_redirect (trap_redirect),
        .stall_ext     (stall_ext),
        .pc_en         (pc_en),
        .fd_en         (fd_en),
        .fd_flush      (fd_flush),
        .de_flush      (de_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .fwd_ls        (fwd_ls)
    );

    always #5 clk = ~clk;

    function automatic bit m_hit(input int i, input logic [4:0] rs, input logic u);
        return u && (rs != 0) && mv[i] && ((mop[i] == 1) || (mop[i] == 2))
            && (mrd[i] != 0) && (mrd[i] == rs);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic u);
        if (m_hit(0, rs, u) && (mop[0] == 1)) return 2'd1;
        if (m_hit(1, rs, u) && (mop[1] == 1)) return 2'd2;
        if (m_hit(1, rs, u) && (mop[1] == 2)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic m_eval();
        bit lu;
        lu = (m_hit(0, id_rs1, id_rs1use) && (mop[0] == 2))
          || (m_hit(0, id_rs2, id_rs2use) && (mop[0] == 2) && (id_optype != 3));
        e_a  = m_fwd(id_rs1, id_rs1use);
        e_b  = m_fwd(id_rs2, id_rs2use);
        e_ls = mv[0] && (mop[0] == 3) && m_hit(1, mrs2[0], 1'b1) && (mop[1] == 2);
        e_pc = 1'b1; e_fd = 1'b1; e_ff = 1'b0; e_df = 1'b0;
        if (stall_ext) begin
            e_pc = 1'b0; e_fd = 1'b0;
        end else if (trap_redirect) begin
            e_ff = 1'b1; e_df = 1'b1;
        end else if (lu) begin
            e_pc = 1'b0; e_fd = 1'b0; e_df = 1'b1;
        end else if (id_branch) begin
            e_ff = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic check(input string tag);
        #1;
        m_eval();
        chk({tag, ".pc_en"},    pc_en,    e_pc);
        chk({tag, ".fd_en"},    fd_en,    e_fd);
        chk({tag, ".fd_flush"}, fd_flush, e_ff);
        chk({tag, ".de_flush"}, de_flush, e_df);
        chk({tag, ".fwd_a"},    fwd_a,    e_a);
        chk({tag, ".fwd_b"},    fwd_b,    e_b);
        chk({tag, ".fwd_ls"},   fwd_ls,   e_ls);
    endtask

    task automatic tick();
        m_eval();
        @(posedge clk);
        if (rst_n && !stall_ext) begin
            if (trap_redirect) begin
                mv[0] = 1'b0;
                mv[1] = 1'b0;
            end else begin
                mv[1] = mv[0]; mrd[1] = mrd[0]; mop[1] = mop[0]; mrs2[1] = mrs2[0];
                mv[0] = !e_df; mrd[0] = id_rd; mop[0] = id_optype; mrs2[0] = id_rs2;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [1:0] op, input logic br);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1use = u1; id_rs2use = u2; id_optype = op; id_branch = br;
    endtask

    initial begin
        rst_n = 1'b0; trap_redirect = 1'b0; stall_ext = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("reset");
        chk("reset.pc_en_const", pc_en, 1);
        chk("reset.fd_en_const", fd_en, 1);
        chk("reset.fwd_a_const", fwd_a, 0);
        #1 rst_n = 1'b1;
        tick();

        // ALU -> ALU back-to-back, then with one instruction between
        drive(1, 2, 5, 1, 1, 1, 0); check("add_x5"); tick();
        drive(5, 0, 6, 1, 0, 1, 0); check("addi_b2b");
        chk("b2b.fwd_a", fwd_a, 1); chk("b2b.pc_en", pc_en, 1); tick();
        drive(1, 2, 5, 1, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(5, 0, 6, 1, 0, 1, 0); check("addi_gap");
        chk("gap.fwd_a", fwd_a, 2); tick();

        // Load-use: one stall cycle, then MEM load forward
        drive(2, 0, 5, 1, 0, 2, 0); tick();
        drive(5, 1, 7, 1, 1, 1, 0); check("lu_stall");
        chk("lu.pc_en", pc_en, 0); chk("lu.fd_en", fd_en, 0);
        chk("lu.de_flush", de_flush, 1); chk("lu.fd_flush", fd_flush, 0); tick();
        check("lu_after");
        chk("lu_after.fwd_a", fwd_a, 3); chk("lu_after.pc_en", pc_en, 1); tick();

        // Load then store of the loaded value: no stall, fwd_ls later
        drive(2, 0, 5, 1, 0, 2, 0); tick();
        drive(2, 5, 0, 1, 1, 3, 0); check("ld_st");
        chk("ld_st.pc_en", pc_en, 1); chk("ld_st.de_flush", de_flush, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); check("st_in_ex");
        chk("st_in_ex.fwd_ls", fwd_ls, 1); tick();

        // Taken branch, then branch depending on a load
        drive(1, 3, 0, 1, 1, 0, 1); check("beq");
        chk("beq.fd_flush", fd_flush, 1); chk("beq.pc_en", pc_en, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0); check("beq_after");
        chk("beq_after.fd_flush", fd_flush, 0); tick();
        drive(2, 0, 5, 1, 0, 2, 0); tick();
        drive(5, 1, 0, 1, 1, 0, 1); check("beq_lu");
        chk("beq_lu.fd_flush", fd_flush, 0); chk("beq_lu.pc_en", pc_en, 0); tick();
        check("beq_lu2");
        chk("beq_lu2.fd_flush", fd_flush, 1); chk("beq_lu2.fwd_a", fwd_a, 3); tick();

        // Trap redirect clears the scoreboard
        drive(1, 2, 5, 1, 1, 1, 0); tick();
        drive(1, 2, 6, 1, 1, 1, 0); tick();
        drive(5, 6, 9, 1, 1, 1, 0); trap_redirect = 1'b1; check("trap");
        chk("trap.fd_flush", fd_flush, 1); chk("trap.de_flush", de_flush, 1); tick();
        trap_redirect = 1'b0; check("trap_after");
        chk("trap_after.fwd_a", fwd_a, 0); chk("trap_after.fwd_b", fwd_b, 0); tick();

        // External stall for three cycles (trap raised during it must wait)
        drive(1, 2, 5, 1, 1, 1, 0); tick();
        drive(1, 2, 6, 1, 1, 1, 0); tick();
        drive(5, 6, 9, 1, 1, 1, 0); stall_ext = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) trap_redirect = 1'b1;
            check("stall");
            chk("stall.pc_en", pc_en, 0); chk("stall.fd_en", fd_en, 0);
            chk("stall.fd_flush", fd_flush, 0);
            chk("stall.fwd_a", fwd_a, 2); chk("stall.fwd_b", fwd_b, 1);
            tick();
        end
        stall_ext = 1'b0; check("stall_trap");
        chk("stall_trap.fd_flush", fd_flush, 1); tick();
        trap_redirect = 1'b0;

        // Writes to x0 and bubbles never hit
        drive(1, 2, 0, 1, 1, 1, 0); tick();
        drive(0, 0, 7, 1, 1, 1, 0); check("x0");
        chk("x0.fwd_a", fwd_a, 0); tick();
        drive(1, 2, 5, 1, 1, 0, 0); tick();
        drive(5, 5, 6, 1, 1, 1, 0); check("bubble");
        chk("bubble.fwd_a", fwd_a, 0); chk("bubble.fwd_b", fwd_b, 0); tick();

        // Reset in the middle of a load-use stall
        drive(2, 0, 5, 1, 0, 2, 0); tick();
        drive(5, 1, 7, 1, 1, 1, 0); check("pre_rst");
        chk("pre_rst.pc_en", pc_en, 0);
        rst_n = 1'b0; mv[0] = 1'b0; mv[1] = 1'b0;
        check("mid_rst");
        chk("mid_rst.pc_en", pc_en, 1); chk("mid_rst.fd_en", fd_en, 1);
        chk("mid_rst.de_flush", de_flush, 0); chk("mid_rst.fwd_a", fwd_a, 0);
        rst_n = 1'b1;
        tick();

        // Random traffic over a small register window to provoke hits
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            trap_redirect = ($urandom_range(0, 15) == 0);
            stall_ext     = ($urandom_range(0, 7) == 0);
            check("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
